// File: rtl/ser_shift_ctrl.sv
// Control FSM that feeds a downstream bit-serial shifter. It captures a 32-bit operand
// and a shift amount LSB-first, waits for the shifter under a watchdog, then drains the result.
module ser_shift_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_right,
  input  logic       i_arith,
  input  logic       i_op_a,
  input  logic       i_op_b,
  input  logic       i_done,
  input  logic       i_q,
  output logic       o_load,
  output logic       o_d,
  output logic [4:0] o_shamt,
  output logic       o_shamt_msb,
  output logic       o_signbit,
  output logic       o_right,
  output logic       o_busy,
  output logic       o_rd,
  output logic       o_rd_valid,
  output logic       o_ready,
  output logic       o_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_SHIFT   = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0] state;
  logic [4:0] cnt;
  logic [5:0] wd;
  logic       arith_q;

  logic in_capture, in_shift, in_drain, last_bit, timeout;

  assign in_capture = (state == S_CAPTURE);
  assign in_shift   = (state == S_SHIFT);
  assign in_drain   = (state == S_DRAIN);
  assign last_bit   = (cnt == 5'd31);
  assign timeout    = in_shift && !i_done && (wd == 6'd63);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wd          <= '0;
      arith_q     <= 1'b0;
      o_shamt     <= '0;
      o_shamt_msb <= 1'b0;
      o_signbit   <= 1'b0;
      o_right     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state   <= S_CAPTURE;
            cnt     <= '0;
            o_right <= i_right;
            arith_q <= i_arith;
          end
        end
        S_CAPTURE: begin
          for (int i = 0; i < 5; i++) begin
            if (cnt == 5'(i)) o_shamt[i] <= i_op_b;
          end
          if (cnt == 5'd5) o_shamt_msb <= i_op_b;
          if (last_bit) begin
            // Sign fill only matters for arithmetic right shifts; otherwise fill with zero.
            o_signbit <= i_op_a & o_right & arith_q;
            wd        <= '0;
            state     <= S_SHIFT;
          end
          cnt <= cnt + 5'd1;
        end
        S_SHIFT: begin
          wd <= wd + 6'd1;
          if (i_done) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else if (wd == 6'd63) begin
            state <= S_IDLE;
          end
        end
        default: begin
          cnt <= cnt + 5'd1;
          if (last_bit) state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted so an aborted operation never pulses.
  assign o_load     = i_rst & in_capture;
  assign o_d        = i_rst & in_capture & i_op_a;
  assign o_busy     = i_rst & (state != S_IDLE);
  assign o_rd       = i_rst & in_drain & i_q;
  assign o_rd_valid = i_rst & in_drain;
  assign o_ready    = i_rst & in_drain & last_bit;
  assign o_err      = i_rst & timeout;

endmodule

// File: tb/tb_ser_shift_ctrl.sv
// Bench for ser_shift_ctrl: a timeline model predicts every output each cycle from the
// operand words and event times, and directed operations pin the model with literal values.
module tb_ser_shift_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start = 1'b0, i_right = 1'b0, i_arith = 1'b0;
  logic       i_op_a = 1'b0, i_op_b = 1'b0, i_done = 1'b0, i_q = 1'b0;
  logic       o_load, o_d, o_shamt_msb, o_signbit, o_right, o_busy;
  logic       o_rd, o_rd_valid, o_ready, o_err;
  logic [4:0] o_shamt;

  ser_shift_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_right(i_right), .i_arith(i_arith),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_done(i_done), .i_q(i_q),
    .o_load(o_load), .o_d(o_d), .o_shamt(o_shamt), .o_shamt_msb(o_shamt_msb),
    .o_signbit(o_signbit), .o_right(o_right), .o_busy(o_busy), .o_rd(o_rd),
    .o_rd_valid(o_rd_valid), .o_ready(o_ready), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Operand words for the operation being issued; the model snapshots them on acceptance.
  logic [31:0] a_word = '0, b_word = '0, q_word = '0;

  // Timeline model: an operation accepted in cycle t0 captures in t0+1..t0+32, shifts until
  // i_done (or 64 cycles), then drains for 32 cycles after the i_done cycle.
  bit          armed = 1'b0;
  bit          m_active = 1'b0;
  int          m_t0 = 0, m_tdone = -1;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_arith = 1'b0, m_right = 1'b0, m_sign = 1'b0, m_msb = 1'b0;
  logic [4:0]  m_shamt = '0;

  always @(negedge i_clk) begin
    int   age, dage;
    logic e_load, e_d, e_busy, e_rd, e_rdv, e_ready, e_err;
    bit   capturing;
    e_load = 0; e_d = 0; e_busy = 0; e_rd = 0; e_rdv = 0; e_ready = 0; e_err = 0;
    capturing = 0;
    age = cyc - m_t0;
    dage = cyc - m_tdone - 1;
    if (m_active) begin
      e_busy = 1;
      if (age >= 1 && age <= 32) begin
        capturing = 1;
        e_load = 1;
        e_d = m_a[5'(age - 1)];
      end else if (m_tdone < 0) begin
        e_err = !i_done && (age - 33 == 63);
      end else begin
        e_rdv = 1;
        e_rd = i_q;
        e_ready = (dage == 31);
      end
    end
    if (!i_rst) begin
      e_load = 0; e_d = 0; e_busy = 0; e_rd = 0; e_rdv = 0; e_ready = 0; e_err = 0;
    end
    if (armed) begin
      check("o_load", 32'(o_load), 32'(e_load));
      check("o_d", 32'(o_d), 32'(e_d));
      check("o_busy", 32'(o_busy), 32'(e_busy));
      check("o_rd", 32'(o_rd), 32'(e_rd));
      check("o_rd_valid", 32'(o_rd_valid), 32'(e_rdv));
      check("o_ready", 32'(o_ready), 32'(e_ready));
      check("o_err", 32'(o_err), 32'(e_err));
      check("o_right", 32'(o_right), 32'(m_right));
      if (!capturing) begin
        check("o_shamt", 32'(o_shamt), 32'(m_shamt));
        check("o_shamt_msb", 32'(o_shamt_msb), 32'(m_msb));
        check("o_signbit", 32'(o_signbit), 32'(m_sign));
      end
    end
    if (!i_rst) begin
      armed = 1'b1;
      m_active = 0; m_right = 0; m_shamt = '0; m_msb = 0; m_sign = 0;
    end else if (!m_active) begin
      if (i_start) begin
        m_active = 1; m_t0 = cyc; m_tdone = -1;
        m_a = a_word; m_b = b_word; m_right = i_right; m_arith = i_arith;
      end
    end else if (age == 32) begin
      m_shamt = m_b[4:0];
      m_msb = m_b[5];
      m_sign = m_a[31] & m_right & m_arith;
    end else if (age > 32 && m_tdone < 0) begin
      if (i_done) m_tdone = cyc;
      else if (age - 33 == 63) m_active = 0;
    end else if (m_tdone >= 0 && cyc - m_tdone == 32) begin
      m_active = 0;
    end
  end

  // Event log used by the directed checks.
  int n_ready = 0, n_err = 0, n_load = 0, ready_cyc = 0, err_cyc = 0, start_cyc = 0;
  always @(negedge i_clk) begin
    if (o_ready) begin n_ready++; ready_cyc = cyc; end
    if (o_err) begin n_err++; err_cyc = cyc; end
    if (o_load) n_load++;
  end

  // Issue one operation. done_at: SHIFT cycle (1-based) carrying i_done, 0 = never.
  // rst_at: DRAIN cycle in which reset is driven low, -1 = none. restart: extra i_start in CAPTURE.
  task automatic run_op(input logic right, input logic arith, input logic [31:0] a,
                        input logic [31:0] b, input int done_at, input int rst_at,
                        input bit restart);
    a_word = a; b_word = b;
    i_right = right; i_arith = arith; i_start = 1'b1;
    start_cyc = cyc;
    n_load = 0;
    step();
    i_right = ~right; i_arith = ~arith;
    for (int i = 0; i < 32; i++) begin
      i_op_a = a[5'(i)]; i_op_b = b[5'(i)];
      i_start = restart && (i == 5);
      step();
    end
    i_start = 1'b0; i_op_a = 1'b1; i_op_b = 1'b1;
    for (int s = 1; s <= 64; s++) begin
      i_done = (s == done_at);
      step();
      if (s == done_at) break;
    end
    i_done = 1'b0; i_op_a = 1'b0; i_op_b = 1'b0;
    if (done_at == 0) return;
    for (int j = 0; j < 32; j++) begin
      i_q = q_word[5'(j)];
      if (j == rst_at) i_rst = 1'b0;
      step();
      if (j == rst_at) begin
        i_rst = 1'b1;
        return;
      end
    end
    i_q = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_load, o_d, o_busy, o_rd, o_rd_valid, o_ready, o_err,
                o_right, o_signbit, o_shamt_msb, o_shamt});
  endfunction

  initial begin
    int r0, e0;
    i_q = 1'b1;
    repeat (3) step();
    i_rst = 1'b1;
    step();
    @(negedge i_clk);
    check("reset outputs", all_outs(), 32'h0);

    // Left shift, shamt 3, i_done on the second SHIFT cycle.
    q_word = 32'hA5A5_0F0F; r0 = n_ready;
    run_op(1'b0, 1'b0, 32'h1234_5678, 32'h0000_0003, 2, -1, 1'b0);
    check("op1 shamt", 32'(o_shamt), 32'd3);
    check("op1 shamt_msb", 32'(o_shamt_msb), 32'd0);
    check("op1 load cycles", 32'(n_load), 32'd32);
    check("op1 ready latency", 32'(ready_cyc - start_cyc), 32'd66);
    check("op1 ready count", 32'(n_ready - r0), 32'd1);
    step();

    // Arithmetic right shift of a negative word; i_done already high on the first SHIFT cycle.
    q_word = 32'h0000_FFFF;
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'h0000_001F, 1, -1, 1'b0);
    check("op2 signbit", 32'(o_signbit), 32'd1);
    check("op2 right", 32'(o_right), 32'd1);
    check("op2 shamt", 32'(o_shamt), 32'h1F);
    check("op2 ready latency", 32'(ready_cyc - start_cyc), 32'd65);
    step();

    // Same stimulus, logical right shift.
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_001F, 1, -1, 1'b0);
    check("op3 signbit", 32'(o_signbit), 32'd0);
    step();

    // Shift amount bit 5 only.
    q_word = 32'h1357_9BDF;
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0020, 5, -1, 1'b0);
    check("op4 shamt", 32'(o_shamt), 32'd0);
    check("op4 shamt_msb", 32'(o_shamt_msb), 32'd1);
    check("op4 signbit", 32'(o_signbit), 32'd0);
    check("op4 ready latency", 32'(ready_cyc - start_cyc), 32'd69);
    step();

    // Watchdog: i_done never arrives.
    r0 = n_ready; e0 = n_err;
    run_op(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0007, 0, -1, 1'b0);
    @(negedge i_clk);
    check("timeout busy after err", 32'(o_busy), 32'd0);
    check("timeout err count", 32'(n_err - e0), 32'd1);
    check("timeout err latency", 32'(err_cyc - start_cyc), 32'd96);
    check("timeout no ready", 32'(n_ready - r0), 32'd0);
    step();

    // Reset during DRAIN cnt 10, then a fresh operation.
    q_word = 32'hFFFF_FFFF; r0 = n_ready;
    run_op(1'b1, 1'b1, 32'hF000_0001, 32'h0000_0009, 2, 10, 1'b0);
    @(negedge i_clk);
    check("abort outputs", all_outs(), 32'h0);
    check("abort no ready", 32'(n_ready - r0), 32'd0);
    step();
    q_word = 32'h8421_8421; r0 = n_ready;
    run_op(1'b0, 1'b0, 32'h0F0F_0F0F, 32'h0000_0011, 3, -1, 1'b0);
    check("fresh op ready count", 32'(n_ready - r0), 32'd1);
    check("fresh op ready latency", 32'(ready_cyc - start_cyc), 32'd67);
    check("fresh op shamt", 32'(o_shamt), 32'h11);

    // Second i_start during CAPTURE must not launch another operation.
    r0 = n_ready;
    run_op(1'b1, 1'b0, 32'h7654_3210, 32'h0000_0004, 2, -1, 1'b1);
    repeat (40) step();
    @(negedge i_clk);
    check("restart ready count", 32'(n_ready - r0), 32'd1);
    check("restart idle", 32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_shift_ctrl.md
SER_SHIFT_CTRL -- requirements
Module: ser_shift_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port i_rst, input, 1 bit: synchronous reset, active-low (0 = reset).
REQ-004 Port i_start, input, 1 bit: single-cycle request to begin a shift operation; sampled only in IDLE.
REQ-005 Port i_right, input, 1 bit: shift direction (1 = right), sampled with i_start.
REQ-006 Port i_arith, input, 1 bit: arithmetic right shift, sampled with i_start; ignored when i_right = 0.
REQ-007 Port i_op_a, input, 1 bit: serial data operand, LSB first, one bit per cycle in CAPTURE.
REQ-008 Port i_op_b, input, 1 bit: serial shift-amount operand, LSB first, one bit per cycle in CAPTURE.
REQ-009 Port i_done, input, 1 bit: completion flag from the downstream serial shifter.
REQ-010 Port i_q, input, 1 bit: serial result bit from the downstream shifter.
REQ-011 Port o_load, output, 1 bit: shifter load enable.
REQ-012 Port o_d, output, 1 bit: shifter data bit.
REQ-013 Port o_shamt, output, 5 bits: captured shift amount.
REQ-014 Port o_shamt_msb, output, 1 bit: captured bit 5 of the shift amount.
REQ-015 Port o_signbit, output, 1 bit: sign fill bit.
REQ-016 Port o_right, output, 1 bit: latched direction.
REQ-017 Port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-018 Port o_rd, output, 1 bit: serial result bit to the writeback stage.
REQ-019 Port o_rd_valid, output, 1 bit: qualifies o_rd.
REQ-020 Port o_ready, output, 1 bit: one-cycle end-of-operation pulse.
REQ-021 Port o_err, output, 1 bit: one-cycle timeout pulse.

Function
REQ-022 The FSM SHALL have exactly these states: IDLE, CAPTURE, SHIFT, DRAIN; it SHALL use a 5-bit bit counter (cnt) and a 6-bit watchdog counter (wd).
REQ-023 IDLE to CAPTURE: taken when i_start = 1.
- i_right and i_arith are latched.
- cnt is cleared to 0.
- i_start asserted in any other state SHALL be ignored.
REQ-024 CAPTURE lasts exactly 32 cycles, cnt = 0..31.
- o_load = 1 throughout.
- o_d = i_op_a combinationally.
REQ-025 In CAPTURE, i_op_b at cnt 0..4 SHALL be stored into o_shamt[0..4], and i_op_b at cnt 5 into o_shamt_msb; later i_op_b bits are ignored.
REQ-026 In CAPTURE at cnt = 31, o_signbit SHALL be set to i_op_a AND latched i_right AND latched i_arith.
REQ-027 CAPTURE to SHIFT: taken after the cnt = 31 cycle.
- o_load is deasserted the next cycle.
- wd is cleared.
REQ-028 In SHIFT, wd SHALL increment each cycle.
- When i_done = 1: go to DRAIN with cnt = 0.
- When wd reaches 63 without i_done: pulse o_err for one cycle and go to IDLE.
REQ-029 DRAIN lasts exactly 32 cycles, with o_rd = i_q and o_rd_valid = 1.
- At cnt = 31, o_ready SHALL pulse in that same cycle.
- The FSM then goes to IDLE.
REQ-030 Outside CAPTURE, o_d SHALL be 0; outside DRAIN, o_rd and o_rd_valid SHALL be 0.
REQ-031 o_shamt, o_shamt_msb, o_signbit and o_right SHALL hold their captured values from the end of CAPTURE until the next i_start.
REQ-032 cnt SHALL wrap 31 to 0 without any side effect other than the state transition.
REQ-033 If i_done is already 1 on the first SHIFT cycle (for example shamt = 0), DRAIN SHALL start on the next cycle.
REQ-034 Latency from i_start to o_ready SHALL be 32 + (SHIFT cycles) + 32 cycles.

Reset
REQ-035 While i_rst = 0 at a clock edge, the block SHALL:
- enter IDLE;
- clear cnt, wd, o_shamt, o_shamt_msb, o_signbit and o_right;
- drive o_load, o_d, o_busy, o_rd, o_rd_valid, o_ready and o_err to 0.
REQ-036 Reset asserted mid-operation (any state) SHALL abort the operation with no o_ready or o_err pulse; i_start is ignored while i_rst = 0.

Verification
REQ-037 The bench SHALL cover: i_start with i_right = 0, i_op_b stream = 0x00000003, i_done on the 2nd SHIFT cycle -> o_shamt = 3, o_shamt_msb = 0, o_load high for 32 cycles, o_ready exactly 66 cycles after i_start.
REQ-038 The bench SHALL cover: i_right = 1, i_arith = 1, i_op_a = 0x80000000 -> o_signbit = 1 after CAPTURE; the same stimulus with i_arith = 0 -> o_signbit = 0.
REQ-039 The bench SHALL cover: i_op_b = 0x00000020 -> o_shamt = 0, o_shamt_msb = 1.
REQ-040 The bench SHALL cover: i_done held 0 in SHIFT -> o_err pulses once 64 cycles after SHIFT entry, o_busy = 0 next cycle, and no o_ready pulse.
REQ-041 The bench SHALL cover: i_rst driven 0 on DRAIN cnt = 10 -> next cycle all outputs = 0 and state IDLE; a fresh i_start then completes normally.
REQ-042 The bench SHALL cover: a second i_start during CAPTURE -> ignored, and exactly one o_ready pulse occurs.
